// File: rtl/alu_pkg.sv
// Shared command codes, FSM states and command classification for alu_mc.
// Optional divider build: define ALU_DIV_EN.
package alu_pkg;

    localparam int unsigned EXE_CMD_LEN = 4;

    typedef enum logic [EXE_CMD_LEN-1:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_AND  = 4'd2,
        CMD_OR   = 4'd3,
        CMD_XOR  = 4'd4,
        CMD_SLL  = 4'd5,
        CMD_SRL  = 4'd6,
        CMD_SRA  = 4'd7,
        CMD_MUL  = 4'd8,
        CMD_DIVU = 4'd9,
        CMD_REMU = 4'd10
    } exe_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // True for commands that run through the WIDTH-cycle iterative unit
    function automatic logic is_iter_cmd(input logic [EXE_CMD_LEN-1:0] cmd);
`ifdef ALU_DIV_EN
        return (cmd == CMD_MUL) || (cmd == CMD_DIVU) || (cmd == CMD_REMU);
`else
        return cmd == CMD_MUL;
`endif
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// WIDTH-cycle shift-add multiplier; restoring divider when ALU_DIV_EN is defined.
// Outputs suffixed _c are combinational views of the step in progress; done_c
// marks the final step, during which result_c/flag_c hold the committed value.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [EXE_CMD_LEN-1:0] op,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   done_c,
    output logic [WIDTH-1:0]       result_c,
    output logic                   flag_c
);

    logic             run;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] opnd;    // multiplicand, or divisor
    logic [WIDTH-1:0] hi;      // product high half, or partial remainder
    logic [WIDTH-1:0] lo;      // multiplier / product low half, or dividend / quotient
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic             div_mode;
    logic             rem_mode;
    logic [WIDTH:0]   div_rs;
    logic             div_ge;
`endif

    // One multiply or divide step on the current partial state
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        hi_nxt   = mul_sum[WIDTH:1];
        lo_nxt   = {mul_sum[0], lo[WIDTH-1:1]};
        result_c = lo_nxt;
        flag_c   = |hi_nxt;
`ifdef ALU_DIV_EN
        div_rs = {hi, lo[WIDTH-1]};
        div_ge = div_rs >= {1'b0, opnd};
        if (div_mode) begin
            // a zero divisor always "fits": quotient fills with ones, remainder ends as a
            hi_nxt   = div_ge ? WIDTH'(div_rs - {1'b0, opnd}) : div_rs[WIDTH-1:0];
            lo_nxt   = {lo[WIDTH-2:0], div_ge};
            result_c = rem_mode ? hi_nxt : lo_nxt;
            flag_c   = (opnd == '0);
        end
`endif
        done_c = run && (cnt == SHW'(WIDTH - 1));
    end

    // Operand capture on start, then one step per cycle until the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            opnd <= '0;
            hi   <= '0;
            lo   <= '0;
`ifdef ALU_DIV_EN
            div_mode <= 1'b0;
            rem_mode <= 1'b0;
`endif
        end else if (start && is_iter_cmd(op)) begin
            run <= 1'b1;
            cnt <= '0;
            hi  <= '0;
`ifdef ALU_DIV_EN
            div_mode <= (op != CMD_MUL);
            rem_mode <= (op == CMD_REMU);
            opnd     <= (op == CMD_MUL) ? a : b;
            lo       <= (op == CMD_MUL) ? b : a;
`else
            opnd <= a;
            lo   <= b;
`endif
        end else if (run) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt + SHW'(1);
            if (done_c) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides, one op in flight.
// Optional divider build: define ALU_DIV_EN (DIVU/REMU become iterative).
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       alu_a,
    input  logic [WIDTH-1:0]       alu_b,
    input  logic [EXE_CMD_LEN-1:0] exe_cmd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       alu_result,
    output logic                   flag_zero,
    output logic                   flag_carry,
    output logic                   busy
);

    alu_state_e              state;
    alu_state_e              state_nxt;
    logic                    accept_c;
    logic                    start_c;
    logic                    iter_done_c;
    logic [WIDTH-1:0]        iter_result_c;
    logic                    iter_flag_c;
    logic [WIDTH-1:0]        sc_result_c;
    logic                    sc_carry_c;
    logic [WIDTH:0]          add_sum;
    logic [SHW-1:0]          shamt;
    logic                    shift_ovf;
    logic signed [WIDTH-1:0] sra_val;

    alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .op       (exe_cmd),
        .a        (alu_a),
        .b        (alu_b),
        .done_c   (iter_done_c),
        .result_c (iter_result_c),
        .flag_c   (iter_flag_c)
    );

    // Single-cycle operations, evaluated on the presented operands
    always_comb begin
        sc_result_c = '0;
        sc_carry_c  = 1'b0;
        add_sum     = {1'b0, alu_a} + {1'b0, alu_b};
        shamt       = alu_b[SHW-1:0];
        // WIDTH is a power of two, so any upper bit set means b >= WIDTH
        shift_ovf   = |alu_b[WIDTH-1:SHW];
        sra_val     = $signed(alu_a) >>> shamt;
        case (exe_cmd)
            CMD_ADD: begin
                sc_carry_c  = add_sum[WIDTH];
                sc_result_c = add_sum[WIDTH] ? '1 : add_sum[WIDTH-1:0];
            end
            CMD_SUB: begin
                sc_result_c = alu_a - alu_b;
                sc_carry_c  = (alu_b > alu_a);
            end
            CMD_AND: sc_result_c = alu_a & alu_b;
            CMD_OR:  sc_result_c = alu_a | alu_b;
            CMD_XOR: sc_result_c = alu_a ^ alu_b;
            CMD_SLL: sc_result_c = shift_ovf ? '0 : (alu_a << shamt);
            CMD_SRL: sc_result_c = shift_ovf ? '0 : (alu_a >> shamt);
            CMD_SRA: sc_result_c = shift_ovf ? {WIDTH{alu_a[WIDTH-1]}} : sra_val;
            default: ;
        endcase
    end

    // Next state and handshake; DONE accepts back-to-back when the result is taken
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        accept_c  = in_valid && in_ready;
        start_c   = accept_c && is_iter_cmd(exe_cmd);
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = start_c ? ITER : DONE;
                end
            end
            ITER: begin
                if (iter_done_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept_c) begin
                    state_nxt = start_c ? ITER : DONE;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered status and result; result/flags only change when a result commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            alu_result <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == ITER);
            if (accept_c && !start_c) begin
                alu_result <= sc_result_c;
                flag_carry <= sc_carry_c;
                flag_zero  <= (sc_result_c == '0);
            end else if ((state == ITER) && iter_done_c) begin
                alu_result <= iter_result_c;
                flag_carry <= iter_flag_c;
                flag_zero  <= (iter_result_c == '0);
            end
        end
    end

endmodule
